// File: rtl/ahb_arb_pkg.sv
// Shared AHB encodings, arbiter state and buffered-request type for the
// two-port SDRAM arbiter.
package ahb_arb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } arb_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
    } req_t;

endpackage

// File: rtl/ahb_req_capture.sv
// Per-port request buffer: latches one AHB-Lite address phase and stalls the
// master until the arbiter reports completion of its data phase.
module ahb_req_capture
    import ahb_arb_pkg::*;
(
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        hsel_i,
    input  logic        hready_i,
    input  logic [1:0]  htrans_i,
    input  logic [31:0] haddr_i,
    input  logic        hwrite_i,
    input  logic [2:0]  hsize_i,
    input  logic        done_i,
    output logic        pend_o,
    output req_t        req_o,
    output logic        hreadyout_o
);

    logic pend_q, pend_d;
    req_t req_q, req_d;
    logic capture;

    // The completion cycle releases the stall, so a pipelined follow-on
    // request can be captured in that same cycle.
    assign hreadyout_o = ~pend_q | done_i;
    assign capture     = hsel_i & htrans_i[1] & hready_i & hreadyout_o;
    assign pend_o      = pend_q;
    assign req_o       = req_q;

    always_comb begin
        pend_d = pend_q;
        req_d  = req_q;
        if (done_i) begin
            pend_d = 1'b0;
        end
        if (capture) begin
            pend_d = 1'b1;
            req_d  = '{addr: haddr_i, write: hwrite_i, size: hsize_i};
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_ff @(posedge HCLK) begin
        req_q <= req_d;
    end

endmodule

// File: rtl/ahb_sdram_arb.sv
// Two-port AHB-Lite arbiter in front of a single SDRAM slave; requests are
// buffered per port and replayed one at a time as ADDR then DATA phases.
module ahb_sdram_arb
    import ahb_arb_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL0,
    input  logic        HREADY0,
    input  logic [31:0] HADDR0,
    input  logic [1:0]  HTRANS0,
    input  logic        HWRITE0,
    input  logic [2:0]  HSIZE0,
    input  logic [31:0] HWDATA0,
    output logic        HREADYOUT0,
    output logic [31:0] HRDATA0,
    output logic        HRESP0,
    input  logic        HSEL1,
    input  logic        HREADY1,
    input  logic [31:0] HADDR1,
    input  logic [1:0]  HTRANS1,
    input  logic        HWRITE1,
    input  logic [2:0]  HSIZE1,
    input  logic [31:0] HWDATA1,
    output logic        HREADYOUT1,
    output logic [31:0] HRDATA1,
    output logic        HRESP1,
    output logic        S_HSEL,
    output logic        S_HREADY,
    output logic [31:0] S_HADDR,
    output logic [1:0]  S_HTRANS,
    output logic        S_HWRITE,
    output logic [2:0]  S_HSIZE,
    output logic [31:0] S_HWDATA,
    input  logic        S_HREADYOUT,
    input  logic [31:0] S_HRDATA,
    input  logic        S_HRESP
);

    arb_state_e state_q, state_d;
    logic       grant_q, grant_d;
    logic       last_grant_q, last_grant_d;
    req_t       s_req_q, s_req_d;

    logic [1:0] pend;
    req_t       req0, req1;
    logic       data_done;
    logic       sel;
    logic       unused_resp;

    assign data_done   = (state_q == ST_DATA) & S_HREADYOUT;
    assign unused_resp = S_HRESP;

    ahb_req_capture u_cap0 (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .hsel_i      (HSEL0),
        .hready_i    (HREADY0),
        .htrans_i    (HTRANS0),
        .haddr_i     (HADDR0),
        .hwrite_i    (HWRITE0),
        .hsize_i     (HSIZE0),
        .done_i      (data_done & ~grant_q),
        .pend_o      (pend[0]),
        .req_o       (req0),
        .hreadyout_o (HREADYOUT0)
    );

    ahb_req_capture u_cap1 (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .hsel_i      (HSEL1),
        .hready_i    (HREADY1),
        .htrans_i    (HTRANS1),
        .haddr_i     (HADDR1),
        .hwrite_i    (HWRITE1),
        .hsize_i     (HSIZE1),
        .done_i      (data_done & grant_q),
        .pend_o      (pend[1]),
        .req_o       (req1),
        .hreadyout_o (HREADYOUT1)
    );

    // Contention goes to the port not served last when round-robin is on.
    always_comb begin
        if (pend == 2'b11) begin
            sel = RR_EN ? ~last_grant_q : 1'b0;
        end else begin
            sel = pend[1] & ~pend[0];
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            s_req_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            s_req_q      <= s_req_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        s_req_d      = s_req_q;
        case (state_q)
            ST_IDLE: begin
                if (|pend) begin
                    state_d = ST_ADDR;
                    grant_d = sel;
                    s_req_d = sel ? req1 : req0;
                end
            end
            ST_ADDR: state_d = ST_DATA;
            ST_DATA: begin
                if (S_HREADYOUT) begin
                    state_d      = ST_IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Address fields come from a register so they hold after the ADDR cycle.
    assign S_HADDR  = s_req_q.addr;
    assign S_HWRITE = s_req_q.write;
    assign S_HSIZE  = s_req_q.size;
    assign HRESP0   = 1'b0;
    assign HRESP1   = 1'b0;

    always_comb begin
        S_HSEL   = 1'b0;
        S_HTRANS = HTRANS_IDLE;
        S_HREADY = 1'b1;
        S_HWDATA = grant_q ? HWDATA1 : HWDATA0;
        HRDATA0  = '0;
        HRDATA1  = '0;
        if (state_q == ST_ADDR) begin
            S_HSEL   = 1'b1;
            S_HTRANS = HTRANS_NONSEQ;
        end
        if (state_q == ST_DATA) begin
            S_HREADY = S_HREADYOUT;
        end
        if (state_q != ST_IDLE) begin
            if (grant_q) begin
                HRDATA1 = S_HRDATA;
            end else begin
                HRDATA0 = S_HRDATA;
            end
        end
    end

endmodule

// File: tb/tb_ahb_sdram_arb.sv
// Bench for ahb_sdram_arb: a round-robin and a fixed-priority instance driven
// by queue-based masters and a wait-state slave, checked against a transaction model.
module tb_ahb_sdram_arb;

    typedef struct packed {
        logic [31:0] addr;
        logic        w;
        logic [2:0]  size;
        logic [31:0] wdata;
    } treq_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // Master-side index k = env*2 + port; env 0 = round-robin, env 1 = fixed priority
    logic [3:0]        hsel, hwrite;
    logic [3:0][1:0]   htrans;
    logic [3:0][2:0]   hsize;
    logic [3:0][31:0]  haddr, hwdata;
    wire  [3:0]        hro, hresp;
    wire  [3:0][31:0]  hrd;

    logic [1:0]        s_hro, s_hresp;
    logic [1:0][31:0]  s_hrd;
    wire  [1:0]        s_hsel, s_hready, s_hwrite;
    wire  [1:0][1:0]   s_htrans;
    wire  [1:0][2:0]   s_hsize;
    wire  [1:0][31:0]  s_haddr, s_hwdata;

    ahb_sdram_arb #(.RR_EN(1'b1)) u_rr (
        .HCLK(clk), .HRESETn(rst_n),
        .HSEL0(hsel[0]), .HREADY0(hro[0]), .HADDR0(haddr[0]), .HTRANS0(htrans[0]),
        .HWRITE0(hwrite[0]), .HSIZE0(hsize[0]), .HWDATA0(hwdata[0]),
        .HREADYOUT0(hro[0]), .HRDATA0(hrd[0]), .HRESP0(hresp[0]),
        .HSEL1(hsel[1]), .HREADY1(hro[1]), .HADDR1(haddr[1]), .HTRANS1(htrans[1]),
        .HWRITE1(hwrite[1]), .HSIZE1(hsize[1]), .HWDATA1(hwdata[1]),
        .HREADYOUT1(hro[1]), .HRDATA1(hrd[1]), .HRESP1(hresp[1]),
        .S_HSEL(s_hsel[0]), .S_HREADY(s_hready[0]), .S_HADDR(s_haddr[0]), .S_HTRANS(s_htrans[0]),
        .S_HWRITE(s_hwrite[0]), .S_HSIZE(s_hsize[0]), .S_HWDATA(s_hwdata[0]),
        .S_HREADYOUT(s_hro[0]), .S_HRDATA(s_hrd[0]), .S_HRESP(s_hresp[0])
    );

    ahb_sdram_arb #(.RR_EN(1'b0)) u_fp (
        .HCLK(clk), .HRESETn(rst_n),
        .HSEL0(hsel[2]), .HREADY0(hro[2]), .HADDR0(haddr[2]), .HTRANS0(htrans[2]),
        .HWRITE0(hwrite[2]), .HSIZE0(hsize[2]), .HWDATA0(hwdata[2]),
        .HREADYOUT0(hro[2]), .HRDATA0(hrd[2]), .HRESP0(hresp[2]),
        .HSEL1(hsel[3]), .HREADY1(hro[3]), .HADDR1(haddr[3]), .HTRANS1(htrans[3]),
        .HWRITE1(hwrite[3]), .HSIZE1(hsize[3]), .HWDATA1(hwdata[3]),
        .HREADYOUT1(hro[3]), .HRDATA1(hrd[3]), .HRESP1(hresp[3]),
        .S_HSEL(s_hsel[1]), .S_HREADY(s_hready[1]), .S_HADDR(s_haddr[1]), .S_HTRANS(s_htrans[1]),
        .S_HWRITE(s_hwrite[1]), .S_HSIZE(s_hsize[1]), .S_HWDATA(s_hwdata[1]),
        .S_HREADYOUT(s_hro[1]), .S_HRDATA(s_hrd[1]), .S_HRESP(s_hresp[1])
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Master, slave and model state
    treq_t mq[4][$];
    treq_t m_cur[4];
    bit    m_act[4], m_data[4], acc_prev[4], ro_prev[4];
    int    noise_mode = 0;
    bit    sl_data[2], sl_acc_prev[2];
    int    sl_wait[2];
    int    fixed_wait = -1;

    bit    pv[4];
    treq_t preq[4];
    int    pcyc[4], waited[4];
    bit    in_txn[2];
    int    tport[2], acyc[2], freec[2], lastg[2];
    int    glog[2][$];

    int          ro0_low = 0;
    int          nonseq_cnt = 0;
    logic [31:0] obs_addr = '0;
    logic [31:0] obs_wdata = '0;

    function automatic treq_t rand_req();
        treq_t r;
        r.addr  = $urandom;
        r.w     = 1'($urandom_range(0, 1));
        r.size  = 3'($urandom_range(0, 2));
        r.wdata = $urandom;
        return r;
    endfunction

    task automatic drive_inputs();
        for (int e = 0; e < 2; e++) begin
            if (!rst_n) begin
                sl_data[e] = 1'b0;
                s_hro[e]   = 1'b1;
            end else begin
                if (sl_acc_prev[e]) begin
                    sl_data[e] = 1'b1;
                    sl_wait[e] = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
                end else if (sl_data[e] && s_hro[e]) begin
                    sl_data[e] = 1'b0;
                end
                if (sl_data[e] && sl_wait[e] > 0) begin
                    s_hro[e] = 1'b0;
                    sl_wait[e]--;
                end else begin
                    s_hro[e] = 1'b1;
                end
            end
            s_hrd[e]   = $urandom;
            s_hresp[e] = 1'($urandom_range(0, 1));
        end
        for (int k = 0; k < 4; k++) begin
            if (!rst_n) begin
                m_act[k]  = 1'b0;
                m_data[k] = 1'b0;
                hsel[k]   = 1'b0;
                htrans[k] = 2'b00;
            end else begin
                if (acc_prev[k]) begin
                    m_data[k] = 1'b1;
                    hwdata[k] = m_cur[k].wdata;
                    m_act[k]  = 1'b0;
                end else if (m_data[k] && ro_prev[k]) begin
                    m_data[k] = 1'b0;
                end
                if (!m_act[k] && mq[k].size() > 0) begin
                    m_cur[k] = mq[k].pop_front();
                    m_act[k] = 1'b1;
                end
                if (m_act[k]) begin
                    hsel[k]   = 1'b1;
                    htrans[k] = 2'b10;
                    haddr[k]  = m_cur[k].addr;
                    hwrite[k] = m_cur[k].w;
                    hsize[k]  = m_cur[k].size;
                end else if (noise_mode == 1) begin
                    hsel[k]   = 1'b1;
                    htrans[k] = 2'b00;
                end else begin
                    hsel[k]   = 1'($urandom_range(0, 1));
                    htrans[k] = {1'b0, 1'($urandom_range(0, 1))};
                    haddr[k]  = $urandom;
                    hwrite[k] = 1'($urandom_range(0, 1));
                    hsize[k]  = 3'($urandom_range(0, 2));
                end
                if (!m_data[k]) hwdata[k] = $urandom;
            end
        end
    endtask

    task automatic model_step();
        int  n;
        int  b;
        int  g;
        bit  el0, el1, exp_addr, comp;
        bit  er[2];
        n = cyc;
        for (int e = 0; e < 2; e++) begin
            b = e * 2;
            if (!rst_n) begin
                check_val("rst_hreadyout0", 32'(hro[b]), 32'd1);
                check_val("rst_hreadyout1", 32'(hro[b+1]), 32'd1);
                check_val("rst_s_htrans", 32'(s_htrans[e]), 32'd0);
                check_val("rst_s_hsel", 32'(s_hsel[e]), 32'd0);
                check_val("rst_s_haddr", s_haddr[e], 32'd0);
                check_val("rst_s_hwrite_hsize", 32'({s_hwrite[e], s_hsize[e]}), 32'd0);
                pv[b] = 0; pv[b+1] = 0; waited[b] = 0; waited[b+1] = 0;
                in_txn[e] = 0; lastg[e] = 1; freec[e] = n + 1;
                continue;
            end
            el0 = pv[b]   && (pcyc[b]   <= n - 2);
            el1 = pv[b+1] && (pcyc[b+1] <= n - 2);
            exp_addr = !in_txn[e] && (n - 1 >= freec[e]) && (el0 || el1);
            if (e == 0 && s_htrans[0] == 2'b10) nonseq_cnt++;
            check_val("s_htrans", 32'(s_htrans[e]), exp_addr ? 32'd2 : 32'd0);
            check_val("s_hsel", 32'(s_hsel[e]), 32'(exp_addr));
            if (exp_addr) begin
                if (el0 && el1) g = (e == 0) ? 1 - lastg[e] : 0;
                else            g = el1 ? 1 : 0;
                check_val("grant_addr", s_haddr[e], preq[b+g].addr);
                check_val("grant_write", 32'(s_hwrite[e]), 32'(preq[b+g].w));
                check_val("grant_size", 32'(s_hsize[e]), 32'(preq[b+g].size));
                check_val("addr_hready", 32'(s_hready[e]), 32'd1);
                if ((g == 0 && el1) || (g == 1 && el0)) waited[b+1-g]++;
                if (e == 0) check_val("starvation", 32'(waited[b+g] <= 1), 32'd1);
                waited[b+g] = 0;
                in_txn[e] = 1; tport[e] = g; acyc[e] = n;
                glog[e].push_back(g);
                if (e == 0) obs_addr = s_haddr[0];
            end
            comp = in_txn[e] && (n > acyc[e]) && s_hro[e];
            if (in_txn[e] && n > acyc[e]) begin
                check_val("s_hwdata", s_hwdata[e], preq[b+tport[e]].wdata);
                check_val("data_hready", 32'(s_hready[e]), 32'(s_hro[e]));
                if (e == 0) obs_wdata = s_hwdata[0];
            end
            for (int p = 0; p < 2; p++) begin
                er[p] = !(pv[b+p] && pcyc[b+p] < n) || (comp && tport[e] == p);
                check_val($sformatf("hreadyout_e%0d_p%0d", e, p), 32'(hro[b+p]), 32'(er[p]));
                check_val("hresp", 32'(hresp[b+p]), 32'd0);
                if (comp && tport[e] == p)
                    check_val("hrdata_done", hrd[b+p], s_hrd[e]);
                else if (!(in_txn[e] && tport[e] == p))
                    check_val("hrdata_idle", hrd[b+p], 32'd0);
            end
            if (comp) begin
                pv[b+tport[e]] = 0; in_txn[e] = 0; lastg[e] = tport[e]; freec[e] = n + 1;
            end
            for (int p = 0; p < 2; p++) begin
                if (hsel[b+p] && htrans[b+p][1] && er[p]) begin
                    pv[b+p]   = 1;
                    preq[b+p] = '{addr: haddr[b+p], w: hwrite[b+p], size: hsize[b+p],
                                  wdata: m_cur[b+p].wdata};
                    pcyc[b+p] = n;
                end
            end
        end
        if (!hro[0]) ro0_low++;
        for (int k = 0; k < 4; k++) begin
            acc_prev[k] = hsel[k] && htrans[k][1] && hro[k];
            ro_prev[k]  = hro[k];
        end
        for (int e = 0; e < 2; e++)
            sl_acc_prev[e] = s_hsel[e] && s_htrans[e][1] && s_hready[e];
    endtask

    task automatic step(input bit rst_lvl);
        @(posedge clk);
        #1;
        rst_n = rst_lvl;
        drive_inputs();
        @(negedge clk);
        model_step();
        cyc++;
    endtask

    function automatic bit busy();
        bit b;
        b = 0;
        for (int k = 0; k < 4; k++)
            if (mq[k].size() > 0 || m_act[k] || m_data[k] || pv[k]) b = 1;
        if (in_txn[0] || in_txn[1]) b = 1;
        return b;
    endfunction

    task automatic drain(input string tag, input int maxc);
        int c;
        c = 0;
        while (busy() && c < maxc) begin
            step(1'b1);
            c++;
        end
        check_val(tag, 32'(busy()), 32'd0);
        repeat (2) step(1'b1);
    endtask

    initial begin
        int c;
        int gsz;
        treq_t r;
        rst_n = 1'b0;
        hsel = '0; htrans = '0; hwrite = '0; hsize = '0; haddr = '0; hwdata = '0;
        s_hro = 2'b11; s_hrd = '0; s_hresp = '0;
        for (int e = 0; e < 2; e++) begin
            lastg[e] = 1; freec[e] = 0;
        end
        repeat (3) step(1'b0);
        step(1'b1);

        // Single write, three slave wait states
        fixed_wait = 3;
        ro0_low = 0;
        r = '{addr: 32'h6000_0010, w: 1'b1, size: 3'd2, wdata: 32'hDEAD_BEEF};
        mq[0].push_back(r);
        drain("t1_drain", 50);
        check_val("t1_stall_cycles", 32'(ro0_low), 32'd5);
        check_val("t1_s_haddr", obs_addr, 32'h6000_0010);
        check_val("t1_s_hwdata", obs_wdata, 32'hDEAD_BEEF);
        fixed_wait = -1;

        // Simultaneous reads from reset state
        step(1'b0); step(1'b0); step(1'b1);
        glog[0].delete();
        r = rand_req(); r.w = 1'b0; mq[0].push_back(r);
        r = rand_req(); r.w = 1'b0; mq[1].push_back(r);
        drain("t2_drain", 50);
        check_val("t2_count", 32'(glog[0].size()), 32'd2);
        if (glog[0].size() == 2) begin
            check_val("t2_first", 32'(glog[0][0]), 32'd0);
            check_val("t2_second", 32'(glog[0][1]), 32'd1);
        end

        // Back-to-back reads on both ports, round-robin
        glog[0].delete();
        for (int i = 0; i < 8; i++) begin
            r = rand_req(); r.w = 1'b0; mq[0].push_back(r);
            r = rand_req(); r.w = 1'b0; mq[1].push_back(r);
        end
        drain("t3_drain", 400);
        check_val("t3_count", 32'(glog[0].size()), 32'd16);
        for (int i = 0; i < glog[0].size(); i++)
            check_val($sformatf("t3_grant%0d", i), 32'(glog[0][i]), 32'(i % 2));

        // Same load on the fixed-priority instance
        glog[1].delete();
        for (int i = 0; i < 8; i++) begin
            mq[2].push_back(rand_req());
            mq[3].push_back(rand_req());
        end
        drain("t4_drain", 400);
        check_val("t4_count", 32'(glog[1].size()), 32'd16);
        for (int i = 0; i < glog[1].size(); i++)
            check_val($sformatf("t4_grant%0d", i), 32'(glog[1][i]), (i < 8) ? 32'd0 : 32'd1);

        // Reset while port 0 is in DATA and port 1 is pending
        fixed_wait = 3;
        mq[0].push_back(rand_req());
        mq[1].push_back(rand_req());
        c = 0;
        while (!(in_txn[0] && tport[0] == 0 && cyc > acyc[0]) && c < 50) begin
            step(1'b1);
            c++;
        end
        check_val("t5_reach_data", 32'(c < 50), 32'd1);
        gsz = glog[0].size();
        step(1'b0);
        repeat (10) step(1'b1);
        check_val("t5_no_completion", 32'(glog[0].size()), 32'(gsz));
        check_val("t5_hreadyout1", 32'(hro[1]), 32'd1);
        fixed_wait = -1;

        // IDLE transfers with HSEL0 held high
        noise_mode = 1;
        nonseq_cnt = 0;
        repeat (6) step(1'b1);
        check_val("t6_nonseq", 32'(nonseq_cnt), 32'd0);
        check_val("t6_hreadyout0", 32'(hro[0]), 32'd1);
        noise_mode = 0;

        // Random traffic on both instances with one reset in the middle
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 30) begin
                c = int'($urandom_range(0, 3));
                if (mq[c].size() < 2) mq[c].push_back(rand_req());
            end
            step(i != 1500);
        end
        drain("t7_drain", 300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
